// File: rtl/mem_port_arbiter_2to1_if.sv
// Requester, completion and memory-port signals of the 2:1 memory port arbiter.
// The arbiter takes the slave view; requesters plus the memory model take the master view.
interface mem_port_arbiter_2to1_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic              err0;
    logic              err1;
    logic [DATA_W-1:0] rdata;
    logic              sel;
    logic              mem_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_ready, mem_rdata,
        output ack0, ack1, err0, err1, rdata, sel,
        output mem_valid, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_ready, mem_rdata,
        input  ack0, ack1, err0, err1, rdata, sel,
        input  mem_valid, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter_2to1.sv
// Round-robin 2:1 arbiter sharing one memory port between instruction fetch (0) and data (1).
//
// state | meaning
// IDLE  | no transaction on the port; arbitrate pending requests
// BUSY  | port driven with the owner's frozen fields; wait for mem_ready or watchdog expiry
module mem_port_arbiter_2to1 #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input logic                    clk,
    input logic                    rst_n,
    mem_port_arbiter_2to1_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam bit               WDOG_EN   = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] WDOG_LAST = WDOG_EN ? CNT_W'(TIMEOUT - 1) : '0;

    state_t            state;
    logic              owner;
    logic              last_owner;
    logic [CNT_W-1:0]  wdog;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              busy;
    logic              any_req;
    logic              winner;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              done_ok;
    logic              done_tmo;

    always_comb begin
        any_req   = bus.req0 | bus.req1;
        // On a tie the requester that did not own the port last goes next.
        winner    = (bus.req0 & bus.req1) ? ~last_owner : bus.req1;
        win_we    = winner ? bus.we1    : bus.we0;
        win_addr  = winner ? bus.addr1  : bus.addr0;
        win_wdata = winner ? bus.wdata1 : bus.wdata0;
    end

    assign busy     = (state == BUSY);
    assign done_ok  = busy & bus.mem_ready;
    // A ready in the last allowed cycle is a normal completion, not a timeout.
    assign done_tmo = WDOG_EN & busy & ~bus.mem_ready & (wdog == WDOG_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            wdog       <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner   <= winner;
                        we_q    <= win_we;
                        addr_q  <= win_addr;
                        wdata_q <= win_wdata;
                        wdog    <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (done_ok || done_tmo) begin
                        last_owner <= owner;
                        state      <= IDLE;
                    end else begin
                        wdog <= wdog + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sel       = owner;
    assign bus.mem_valid = busy;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.ack0      = done_ok  & ~owner;
    assign bus.ack1      = done_ok  &  owner;
    assign bus.err0      = done_tmo & ~owner;
    assign bus.err1      = done_tmo &  owner;
    assign bus.rdata     = bus.mem_rdata;
endmodule

// File: doc/mem_port_arbiter_2to1.md
Name: mem_port_arbiter_2to1

Overview:
Two-requester arbiter sharing one 32-bit memory port between instruction fetch (requester 0) and data access (requester 1). It selects one requester with round-robin priority and steers its address, write data and write enable through the 2:1 32-bit select path onto the port. It holds the transaction until the memory handshakes, returns the completion (or a timeout error) to the owner, then re-arbitrates.

Parameters:
DATA_W, 32, width of write/read data
ADDR_W, 32, width of address
TIMEOUT, 16, max cycles in BUSY before abort; 0 disables the watchdog
CNT_W, 5, watchdog counter width; must hold TIMEOUT

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req0  in  1  requester 0 transaction request; held until ack0/err0
we0  in  1  requester 0 write enable
addr0  in  ADDR_W  requester 0 address
wdata0  in  DATA_W  requester 0 write data
req1  in  1  requester 1 request; held until ack1/err1
we1  in  1  requester 1 write enable
addr1  in  ADDR_W  requester 1 address
wdata1  in  DATA_W  requester 1 write data
ack0  out  1  requester 0 completion pulse
ack1  out  1  requester 1 completion pulse
err0  out  1  requester 0 timeout pulse
err1  out  1  requester 1 timeout pulse
rdata  out  DATA_W  read data, valid with ack0/ack1
sel  out  1  current owner (0/1), the 2:1 select
mem_valid  out  1  port request
mem_we  out  1  port write enable
mem_addr  out  ADDR_W  port address
mem_wdata  out  DATA_W  port write data
mem_ready  in  1  port completion
mem_rdata  in  DATA_W  port read data

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, sel=0, last_owner=1, wdog=0, mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0; ack0/ack1/err0/err1=0.
- States: IDLE, BUSY.
- IDLE: if no req, stay. If exactly one req, grant it. If both, grant the requester != last_owner (req0 wins the first tie after reset). At the grant edge: sel<=winner; mem_addr/mem_wdata/mem_we<=winner's inputs via the 2:1 select; wdog<=0; state<=BUSY.
- BUSY: mem_valid=1. Port fields stay frozen; requester input changes are ignored. wdog increments each BUSY cycle without mem_ready.
- Completion: in BUSY with mem_ready=1, ack[sel]=1 combinationally in that cycle and rdata=mem_rdata. The next edge sets state<=IDLE and last_owner<=sel. The requester drops req on the same edge.
- Timeout (TIMEOUT>0): in BUSY with mem_ready=0 and wdog==TIMEOUT-1, err[sel]=1 combinationally. The next edge sets state<=IDLE and last_owner<=sel. BUSY never exceeds TIMEOUT cycles.
- Simultaneous mem_ready and timeout in the same cycle: ack wins, no err.
- Latency: req seen at edge N gives mem_valid high in cycle N+1. With mem_ready in cycle N+1, the ack pulse occurs in cycle N+1. Back-to-back grants need one IDLE cycle, so max throughput is 1 transaction per 2 cycles.
- mem_ready while IDLE: ignored.
- Owner drops req during BUSY (protocol violation): transaction still completes and ack/err still pulses.
- ack/err only ever asserted in BUSY, one-hot by sel, single cycle.
- rdata = mem_rdata at all times; meaningful only with ack.
- rst_n low mid-BUSY: immediate return to reset values; no ack/err for the aborted transaction.

Test Plan:
- Single read: req0=1, addr0=0x00400000, we0=0; mem_ready=1 in the 1st BUSY cycle with mem_rdata=0x8C080004 -> mem_valid 1 cycle, mem_addr=0x00400000, ack0=1 with rdata=0x8C080004, ack1=0.
- Tie after reset: req0=req1=1 every cycle, mem_ready=1 whenever valid -> grants alternate 0,1,0,1; sel toggles; each ack 2 cycles apart.
- Write steering: req1=1, we1=1, addr1=0x10010000, wdata1=0xFFFFFFFF; addr0=0x55555AAA driven concurrently, req0=0 -> mem_we=1, mem_addr=0x10010000, mem_wdata=0xFFFFFFFF; ack1 on mem_ready.
- Timeout: TIMEOUT=16, req0=1, mem_ready held 0 -> err0 in the 16th BUSY cycle, IDLE next; a subsequent tie grants requester 1.
- Ready/timeout collision: mem_ready=1 exactly in BUSY cycle 16 -> ack0=1, err0=0.
- Reset mid-op: rst_n low in BUSY cycle 3 -> mem_valid=0 immediately, no ack/err; after release, a tie grants requester 0.
